frame_stream_tx: RTL and testbench

//  Transmit side of the classifier's pixel stream. The host loads one frame of FRAME_LEN
//  fp32 words into a local buffer; on start the block streams them in order over a

---
 rtl/frontend_pkg.sv | 15 +
 rtl/frame_buf_ram.sv | 28 ++
 rtl/frame_stream_tx.sv | 163 ++++++++++++++++
 tb/tb_frame_stream_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_pkg.sv
// Shared constants and state encoding for the classifier front-end stream blocks.
package frontend_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FRAME_LEN = 784;
    localparam int unsigned ADDR_W    = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } tx_state_t;

endpackage

// File: rtl/frame_buf_ram.sv
// Frame buffer: one host write port and one synchronous (1-cycle latency) read port.
module frame_buf_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 784,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Writes beyond the frame are dropped so the array only spans real pixels.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, wa} < (ADDR_W + 1)'(DEPTH))) begin
            mem[wa] <= wd;
        end
        if (re) begin
            q <= mem[ra];
        end
    end

endmodule

// File: rtl/frame_stream_tx.sv
// Streams one buffered frame to the inference front end, then captures its result.
// Optional m_tlast output is enabled by defining STREAM_TLAST_EN.
module frame_stream_tx
    import frontend_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
`ifdef STREAM_TLAST_EN
    output logic              m_tlast,
`endif
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    tx_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic              reading;
    logic              rd_vld;
    logic              rd_last;
    logic [DATA_W-1:0] ram_q;
    logic              out_last;
    logic              skid_v;
    logic [DATA_W-1:0] skid_data;
    logic              skid_last;
    logic              pop_c;
    logic              issue_c;
    logic [1:0]        occ_c;

    frame_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (FRAME_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk (clk),
        .we  (wr_en && (state == IDLE)),
        .wa  (wr_addr),
        .wd  (wr_data),
        .re  (issue_c),
        .ra  (ptr),
        .q   (ram_q)
    );

    // A read is issued only if its word is guaranteed a slot (output or skid) when it lands.
    assign pop_c   = m_tvalid && m_tready;
    assign occ_c   = 2'(m_tvalid) + 2'(skid_v) + 2'(rd_vld) - 2'(pop_c);
    assign issue_c = reading && (occ_c <= 2'd1);

`ifdef STREAM_TLAST_EN
    assign m_tlast = out_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            done         <= 1'b0;
            s_tready     <= 1'b0;
            ptr          <= '0;
            reading      <= 1'b0;
            rd_vld       <= 1'b0;
            rd_last      <= 1'b0;
            m_tvalid     <= 1'b0;
            m_tdata      <= '0;
            out_last     <= 1'b0;
            skid_v       <= 1'b0;
            skid_data    <= '0;
            skid_last    <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_vld  <= issue_c;
            rd_last <= issue_c && (ptr == LAST_ADDR);

            if (issue_c) begin
                if (ptr == LAST_ADDR) begin
                    ptr     <= '0;
                    reading <= 1'b0;
                end else begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end

            // Output register refills from skid first to keep address order.
            if (pop_c) begin
                if (skid_v) begin
                    m_tdata  <= skid_data;
                    out_last <= skid_last;
                    skid_v   <= rd_vld;
                    if (rd_vld) begin
                        skid_data <= ram_q;
                        skid_last <= rd_last;
                    end
                end else begin
                    m_tvalid <= rd_vld;
                    out_last <= rd_vld && rd_last;
                    if (rd_vld) begin
                        m_tdata <= ram_q;
                    end
                end
            end else if (rd_vld) begin
                if (!m_tvalid) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= ram_q;
                    out_last <= rd_last;
                end else begin
                    skid_v    <= 1'b1;
                    skid_data <= ram_q;
                    skid_last <= rd_last;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= STREAM;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        reading      <= 1'b1;
                        ptr          <= '0;
                    end
                end
                STREAM: begin
                    if (pop_c && out_last) begin
                        state    <= WAIT_RES;
                        s_tready <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (s_tvalid && s_tready) begin
                        state        <= DONE;
                        result       <= s_tdata;
                        result_valid <= 1'b1;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        s_tready     <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Scoreboard bench for frame_stream_tx: frame model in an array, beats/results checked from queues.
module tb_frame_stream_tx;
    import frontend_pkg::*;

    localparam int TIMEOUT = 6000;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                idx;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              busy;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast_w;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit rnd_mode = 1'b0;

    logic [DATA_W-1:0] mem_model [FRAME_LEN];
    beat_t             exp_beats [$];
    logic [DATA_W-1:0] exp_res [$];

    frame_stream_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
`ifdef STREAM_TLAST_EN
        .m_tlast      (m_tlast_w),
`endif
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .result       (result),
        .result_valid (result_valid),
        .done         (done)
    );

`ifndef STREAM_TLAST_EN
    assign m_tlast_w = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready: random or held high.
    always @(posedge clk) begin
        #1;
        m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops expected beats/results when the DUT presents them.
    bit                stall_prev = 1'b0;
    bit                done_prev = 1'b0;
    logic [DATA_W-1:0] data_prev = '0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(m_tvalid), 32'd1);
                check("stall_data", m_tdata, data_prev);
            end
            if (done_prev) check("done_one_cycle", 32'(done), 32'd0);
            if (m_tvalid && m_tready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", m_tdata, 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_data", m_tdata, b.data);
`ifdef STREAM_TLAST_EN
                    check("beat_tlast", 32'(m_tlast_w), 32'(b.last));
`endif
                    if (b.idx == 0) first_cyc = cyc;
                    if (b.idx == FRAME_LEN - 1) last_cyc = cyc;
                end
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    logic [DATA_W-1:0] r;
                    r = exp_res.pop_front();
                    check("done_result", result, r);
                    check("done_result_valid", 32'(result_valid), 32'd1);
                    check("done_busy_low", 32'(busy), 32'd0);
                end
            end
            stall_prev = m_tvalid && !m_tready;
            done_prev  = done;
            data_prev  = m_tdata;
        end
    end

    task automatic load_frame(input bit rnd_data);
        for (int i = 0; i < FRAME_LEN; i++) begin
            mem_model[i] = rnd_data ? $urandom : DATA_W'(i);
            @(posedge clk);
            #1;
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = mem_model[i];
        end
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            beat_t b;
            b.data = mem_model[i];
            b.last = (i == FRAME_LEN - 1);
            b.idx  = i;
            exp_beats.push_back(b);
        end
    endtask

    task automatic issue_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("result_valid_cleared", 32'(result_valid), 32'd0);
        check("tvalid_lat0", 32'(m_tvalid), 32'd0);
        @(posedge clk);
        #1 check("tvalid_lat1", 32'(m_tvalid), 32'd0);
        @(posedge clk);
        #1 check("tvalid_lat2", 32'(m_tvalid), 32'd1);
    endtask

    // mode 0: plain, 1: start/write while busy, 2: early s_tvalid during stream.
    task automatic run_frame(input bit rnd, input logic [DATA_W-1:0] res, input int mode);
        int waited;
        logic [DATA_W-1:0] res_before;
        res_before = result;
        rnd_mode   = rnd;
        push_frame();
        issue_start();
        if (mode == 1) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(5);
            wr_data = 32'hDEAD_BEEF;
        end
        if (mode == 2) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h4000_0000;
        end
        waited = 0;
        while (exp_beats.size() != 0 && waited < TIMEOUT) begin
            @(posedge clk);
            #2;
            waited++;
            if (mode == 1 && waited == 20) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (mode == 2 && exp_beats.size() != 0) check("s_tready_in_stream", 32'(s_tready), 32'd0);
        end
        if (exp_beats.size() != 0) begin
            check("stream_timeout", 32'(exp_beats.size()), 32'd0);
            exp_beats.delete();
        end
        s_tvalid = 1'b0;
        if (!rnd) check("contiguous_span", 32'(last_cyc - first_cyc + 1), 32'(FRAME_LEN));
        if (mode == 2) begin
            check("result_held", result, res_before);
            check("busy_in_wait", 32'(busy), 32'd1);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk);
        check("tvalid_after_last", 32'(m_tvalid), 32'd0);
        check("s_tready_wait", 32'(s_tready), 32'd1);
        s_tvalid = 1'b1;
        s_tdata  = res;
        exp_res.push_back(res);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_seen", 32'(exp_res.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_result", result, res);
        check("idle_result_valid", 32'(result_valid), 32'd1);
        check("idle_s_tready", 32'(s_tready), 32'd0);
        check("idle_tvalid", 32'(m_tvalid), 32'd0);
    endtask

    task automatic reset_mid_frame();
        int waited;
        rnd_mode = 1'b0;
        push_frame();
        issue_start();
        waited = 0;
        while (exp_beats.size() > FRAME_LEN - 100 && waited < TIMEOUT) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("tvalid_before_reset", 32'(m_tvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        exp_beats.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #3;
        check("reset_tvalid", 32'(m_tvalid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_s_tready", 32'(s_tready), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_result_valid", 32'(result_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        load_frame(1'b0);
        run_frame(1'b0, 32'h3F00_0000, 0);
        run_frame(1'b1, 32'h3F00_0000, 2);
        run_frame(1'b1, $urandom, 1);
        run_frame(1'b0, $urandom, 0);
        reset_mid_frame();
        run_frame(1'b1, $urandom, 0);
        load_frame(1'b1);
        run_frame(1'b1, $urandom, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
